// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: PC-stage hold, instruction-memory request/response and decode handshake.
// Member names are from the fetch unit's point of view; master = fetch unit, slave = environment.
interface if_fetch_unit_if;
    logic [31:0] i_pc;
    logic        o_stall_pc;
    logic        i_flush;
    logic        i_halt;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;

    modport master (
        input  i_pc, i_flush, i_halt, i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
        input  i_instr_ready,
        output o_stall_pc, o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
    );

    modport slave (
        output i_pc, i_flush, i_halt, i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
        output i_instr_ready,
        input  o_stall_pc, o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Credit-limited instruction fetch: issues in-order imem requests, tags them with their PC,
// queues responses for decode and silently drops responses that belong to flushed fetches.
module if_fetch_unit #(
    parameter int unsigned QDEPTH = 4
) (
    input  logic           clk,
    input  logic           i_reset,
    if_fetch_unit_if.master bus
);
    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 2;

    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   tag_pc  [QDEPTH];
    logic [AW-1:0] q_wr, q_rd, t_wr, t_rd;
    logic [CW-1:0] q_cnt, out_cnt, drop_cnt;

    logic [SW-1:0] credit_sum_c;
    logic          req_valid_c;
    logic          accept_c;
    logic          rsp_keep_c;
    logic          rsp_drop_c;
    logic          pop_c;
    logic [CW-1:0] drop_flush_c;

    // Requests are only issued while queue, in-flight and to-be-dropped slots leave room.
    always_comb begin
        credit_sum_c = SW'(q_cnt) + SW'(out_cnt) + SW'(drop_cnt);
        req_valid_c  = !i_reset && !bus.i_halt && !bus.i_flush && (credit_sum_c < SW'(QDEPTH));
        accept_c     = req_valid_c && bus.i_imem_req_ready;
        rsp_keep_c   = bus.i_imem_rsp_valid && (drop_cnt == '0);
        rsp_drop_c   = bus.i_imem_rsp_valid && (drop_cnt != '0);
        pop_c        = (q_cnt != '0) && bus.i_instr_ready;
    end

    // Everything in flight at a flush becomes garbage; a response landing in the flush cycle is one of them.
    always_comb begin
        drop_flush_c = drop_cnt + out_cnt;
        if (bus.i_imem_rsp_valid && (drop_flush_c != '0)) begin
            drop_flush_c = drop_flush_c - CW'(1);
        end
    end

    assign bus.o_imem_req_valid = req_valid_c;
    assign bus.o_imem_addr      = bus.i_pc;
    assign bus.o_stall_pc       = i_reset || (!accept_c && !bus.i_flush);
    assign bus.o_instr_valid    = (q_cnt != '0);
    assign bus.o_instr          = q_instr[q_rd];
    assign bus.o_instr_pc       = q_pc[q_rd];

    // PC tags of accepted requests; entry count always equals out_cnt.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            tag_pc[t_wr] <= bus.i_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            q_wr     <= '0;
            q_rd     <= '0;
            t_wr     <= '0;
            t_rd     <= '0;
            q_cnt    <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (bus.i_flush) begin
            q_wr     <= '0;
            q_rd     <= '0;
            t_wr     <= '0;
            t_rd     <= '0;
            q_cnt    <= '0;
            out_cnt  <= '0;
            drop_cnt <= drop_flush_c;
        end else begin
            if (accept_c) begin
                t_wr <= t_wr + AW'(1);
            end
            if (rsp_keep_c) begin
                q_pc[q_wr]    <= tag_pc[t_rd];
                q_instr[q_wr] <= bus.i_imem_rsp_data;
                q_wr          <= q_wr + AW'(1);
                t_rd          <= t_rd + AW'(1);
            end
            if (pop_c) begin
                q_rd <= q_rd + AW'(1);
            end

            case ({rsp_keep_c, pop_c})
                2'b10:   q_cnt <= q_cnt + CW'(1);
                2'b01:   q_cnt <= q_cnt - CW'(1);
                default: q_cnt <= q_cnt;
            endcase

            case ({accept_c, rsp_keep_c})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase

            if (rsp_drop_c) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, backpressure, flush, halt and reset scenarios
// against a 1-cycle in-order memory responder and a PC stage that follows o_stall_pc.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic i_reset;

    if_fetch_unit_if bus();

    if_fetch_unit #(.QDEPTH(4)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pend[$];
    logic [63:0] got[$];
    logic        rsp_en;
    logic [31:0] jump_target;
    int          acc_cnt;
    logic [31:0] last_acc;
    logic        s_req_valid, s_stall, s_instr_valid;
    logic [31:0] s_instr, s_instr_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // One clock: snapshot outputs at negedge, then drive responder and PC stage after the edge.
    task automatic tick();
        logic acc;
        @(negedge clk);
        s_req_valid   = bus.o_imem_req_valid;
        s_stall       = bus.o_stall_pc;
        s_instr_valid = bus.o_instr_valid;
        s_instr       = bus.o_instr;
        s_instr_pc    = bus.o_instr_pc;
        acc = bus.o_imem_req_valid && bus.i_imem_req_ready;
        if (acc) begin
            pend.push_back(bus.o_imem_addr);
            acc_cnt++;
            last_acc = bus.o_imem_addr;
        end
        if (bus.o_instr_valid && bus.i_instr_ready && !bus.i_flush && !i_reset)
            got.push_back({bus.o_instr_pc, bus.o_instr});
        @(posedge clk);
        #1;
        if (acc) chk("stall_on_issue", 32'(s_stall), 32'd0);
        if (rsp_en && pend.size() != 0) begin
            bus.i_imem_rsp_valid = 1'b1;
            bus.i_imem_rsp_data  = mem_word(pend.pop_front());
        end else begin
            bus.i_imem_rsp_valid = 1'b0;
            bus.i_imem_rsp_data  = '0;
        end
        if (bus.i_flush) begin
            bus.i_pc    = jump_target;
            bus.i_flush = 1'b0;
        end else if (!s_stall) begin
            bus.i_pc = bus.i_pc + 32'd4;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_got(input string tag, input int n, input logic [31:0] first_pc);
        logic [63:0] e;
        chk({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            e = got[i];
            chk({tag, "_pc"},    e[63:32], first_pc + 32'(4 * i));
            chk({tag, "_instr"}, e[31:0],  mem_word(first_pc + 32'(4 * i)));
        end
        got.delete();
    endtask

    task automatic do_reset();
        rsp_en      = 1'b0;
        bus.i_halt  = 1'b0;
        bus.i_flush = 1'b0;
        i_reset     = 1'b1;
        ticks(2);
        i_reset              = 1'b0;
        bus.i_pc             = '0;
        bus.i_imem_rsp_valid = 1'b0;
        pend.delete();
        got.delete();
        acc_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        i_reset              = 1'b1;
        bus.i_pc             = '0;
        bus.i_flush          = 1'b1;
        bus.i_halt           = 1'b0;
        bus.i_imem_req_ready = 1'b1;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = '0;
        bus.i_instr_ready    = 1'b1;
        rsp_en               = 1'b0;
        jump_target          = '0;
        acc_cnt              = 0;
        last_acc             = '0;

        // Reset state, with a flush held alongside reset
        tick();
        bus.i_flush = 1'b0;
        tick();
        chk("reset_req_valid",   32'(s_req_valid),   32'd0);
        chk("reset_stall",       32'(s_stall),       32'd1);
        chk("reset_instr_valid", 32'(s_instr_valid), 32'd0);
        chk("reset_instr",       s_instr,            32'd0);
        chk("reset_instr_pc",    s_instr_pc,         32'd0);
        i_reset  = 1'b0;
        bus.i_pc = '0;

        // Streaming: one issue per cycle, delivery in order
        rsp_en = 1'b1;
        ticks(5);
        chk("stream_acc", 32'(acc_cnt), 32'd5);
        bus.i_halt = 1'b1;
        ticks(5);
        check_got("stream", 5, 32'h0);

        // Halt with 3 outstanding
        acc_cnt    = 0;
        bus.i_halt = 1'b0;
        rsp_en     = 1'b0;
        ticks(3);
        chk("halt_acc", 32'(acc_cnt), 32'd3);
        bus.i_halt = 1'b1;
        rsp_en     = 1'b1;
        tick();
        chk("halt_req_valid", 32'(s_req_valid), 32'd0);
        chk("halt_stall",     32'(s_stall),     32'd1);
        ticks(6);
        check_got("halt", 3, 32'h14);
        acc_cnt    = 0;
        bus.i_halt = 1'b0;
        tick();
        chk("halt_resume_acc",  32'(acc_cnt), 32'd1);
        chk("halt_resume_addr", last_acc,     32'h20);

        // Backpressure: credit limit of 4
        do_reset();
        bus.i_instr_ready = 1'b0;
        rsp_en            = 1'b1;
        ticks(8);
        chk("bp_acc",        32'(acc_cnt),       32'd4);
        chk("bp_req_valid",  32'(s_req_valid),   32'd0);
        chk("bp_stall",      32'(s_stall),       32'd1);
        chk("bp_head_valid", 32'(s_instr_valid), 32'd1);
        chk("bp_head_pc",    s_instr_pc,         32'h0);
        chk("bp_head_instr", s_instr,            32'hDEAD_0000);
        bus.i_instr_ready = 1'b1;
        acc_cnt           = 0;
        tick();
        chk("bp_first_pop_acc", 32'(acc_cnt), 32'd0);
        tick();
        chk("bp_resume_acc",  32'(acc_cnt), 32'd1);
        chk("bp_resume_addr", last_acc,     32'h10);
        bus.i_halt = 1'b1;
        ticks(6);
        check_got("bp", 5, 32'h0);

        // Flush with 0x0C queued and 0x10, 0x14 in flight
        do_reset();
        bus.i_instr_ready = 1'b0;
        bus.i_pc          = 32'h0C;
        rsp_en            = 1'b1;
        tick();
        rsp_en = 1'b0;
        ticks(2);
        chk("fl_pre_valid", 32'(s_instr_valid), 32'd1);
        jump_target = 32'h100;
        bus.i_flush = 1'b1;
        tick();
        chk("fl_req_valid", 32'(s_req_valid),  32'd0);
        chk("fl_stall",     32'(s_stall),      32'd0);
        chk("fl_drop",      32'(dut.drop_cnt), 32'd2);
        rsp_en            = 1'b1;
        bus.i_instr_ready = 1'b1;
        tick();
        chk("fl_valid_after", 32'(s_instr_valid), 32'd0);
        chk("fl_first_addr",  last_acc,           32'h100);
        bus.i_halt = 1'b1;
        ticks(6);
        check_got("flush", 1, 32'h100);
        chk("fl_drop_done", 32'(dut.drop_cnt), 32'd0);

        // Response arriving in the flush cycle with OUT=3
        do_reset();
        bus.i_instr_ready = 1'b0;
        ticks(2);
        rsp_en = 1'b1;
        tick();
        jump_target = 32'h200;
        bus.i_flush = 1'b1;
        tick();
        chk("co_drop", 32'(dut.drop_cnt), 32'd2);
        bus.i_instr_ready = 1'b1;
        tick();
        chk("co_valid_after", 32'(s_instr_valid), 32'd0);
        chk("co_first_addr",  last_acc,           32'h200);
        bus.i_halt = 1'b1;
        ticks(6);
        check_got("coincide", 1, 32'h200);

        // Reset mid-operation with 2 queued and 2 outstanding
        do_reset();
        bus.i_instr_ready = 1'b0;
        rsp_en            = 1'b1;
        ticks(2);
        rsp_en = 1'b0;
        ticks(2);
        chk("rs_pre_valid", 32'(s_instr_valid), 32'd1);
        chk("rs_pre_out",   32'(dut.out_cnt),   32'd2);
        i_reset = 1'b1;
        tick();
        chk("rs_req_valid", 32'(s_req_valid), 32'd0);
        chk("rs_stall",     32'(s_stall),     32'd1);
        tick();
        chk("rs_instr_valid",     32'(s_instr_valid), 32'd0);
        chk("rs_instr",           s_instr,            32'd0);
        chk("rs_instr_pc",        s_instr_pc,         32'd0);
        chk("rs_req_valid_held",  32'(s_req_valid),   32'd0);
        chk("rs_out_cleared",     32'(dut.out_cnt),   32'd0);
        i_reset  = 1'b0;
        bus.i_pc = '0;
        pend.delete();
        got.delete();
        rsp_en            = 1'b1;
        bus.i_instr_ready = 1'b1;
        acc_cnt           = 0;
        tick();
        chk("rs_restart_acc",  32'(acc_cnt), 32'd1);
        chk("rs_restart_addr", last_acc,     32'h0);
        bus.i_halt = 1'b1;
        ticks(5);
        check_got("restart", 1, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
